mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised byte-serial memory controller. It arbitrates NUM_PORTS independent request channels (instruction fetch, load/store, future cache refill ports) onto one 8-bit single-port RAM bus, using rotating-priority round-robin. Each transfer is 1, 2 or 4 bytes little-endian, with optional sign extension on reads. Writes to the I/O window are throttled by the UART-full flag. It replaces the fixed two-port controller between the fetch/LSB units and the RAM/IO bus.

## Interface
Parameters:
- NUM_PORTS, 2, number of request channels (2..8); index 0 wins the first arbitration after reset.
- ADDR_W, 32, request and RAM address width.
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are I/O (UART-throttled).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; low freezes all state and outputs.
- req  input  NUM_PORTS  per-port request level; held until done or deliberately dropped (abort).
- we  input  NUM_PORTS  per-port 1 = write, 0 = read.
- size  input  2*NUM_PORTS  per-port 2'b00 byte, 2'b01 half, 2'b10 word; 2'b11 treated as word.
- sext  input  NUM_PORTS  per-port sign-extend read data.
- addr  input  ADDR_W*NUM_PORTS  per-port byte address.
- wdata  input  32*NUM_PORTS  per-port write data, low bytes used.
- done  output  NUM_PORTS  one-cycle completion pulse to the granted port.
- rdata  output  32  read result, valid while a done bit is high.
- busy  output  1  high from grant until return to IDLE.
- data_from_ram  input  8  RAM read byte, valid one cycle after its address.
- uart_full_signal  input  1  UART TX FIFO full.
- signal_to_ram  output  1  1 = read, 0 = write.
- addr_to_ram  output  ADDR_W  RAM byte address.
- data_to_ram  output  8  RAM write byte.

## Operation
- States: IDLE, RD, WR, FIN.
- Reset values: done=0, rdata=0, busy=0, signal_to_ram=1, addr_to_ram=0, data_to_ram=0, round-robin pointer=NUM_PORTS-1, state IDLE.
- Arbitration happens in IDLE when any req is high. The grant goes to the first requesting port scanning upward from pointer+1, modulo NUM_PORTS. The pointer then takes the granted index.
- Latch port, we, size, sext, addr and wdata at grant. nbytes = 1/2/4. Byte k uses addr+k, with ADDR_W-bit wrap.
- RD: issue byte addresses on successive cycles. Capture data_from_ram one cycle after each address into rdata[8k+7:8k]. After the last byte, extend from bit 7 or 15 if sext, else zero-fill. Pulse done, then go to FIN.
- WR: each cycle drive signal_to_ram=0, addr_to_ram=addr+k and data_to_ram=wdata byte k. After the last byte, restore signal_to_ram=1, pulse done, then go to FIN.
- I/O throttle: if the latched address is >= IO_BASE and uart_full_signal=1 at an edge where a write byte would issue, issue nothing. Hold signal_to_ram=1 and retry the next cycle.
- Abort: if the granted port's req falls mid-transfer, go to IDLE next edge with signal_to_ram=1 and no done. Bytes already written stay written.
- FIN: one cycle with done low. busy falls on entry to IDLE. The port must drop or change req in this cycle, or it is re-arbitrated as a new request.
- Idle bus: signal_to_ram=1; addr_to_ram and data_to_ram hold.
- rdy low: no state, pointer or output changes, including the throttle and abort checks.

## Timing
- E0 = edge that grants in IDLE; it also registers byte-0 address (and data for writes).
- Read of n bytes: byte k address at E(k), captured at E(k+1); done high for the cycle after E(n); FIN at E(n+1); IDLE at E(n+2). A word read is done 5 cycles after grant.
- Write of n bytes: byte k on the bus after E(k); done high for the cycle after E(n); IDLE at E(n+2). Each throttled cycle adds one cycle.
- Back-to-back grants are separated by at least one FIN cycle.
- Asynchronous reset mid-transfer: all outputs take reset values immediately; no done is issued.

## Test plan
- NUM_PORTS=2, port0 reads word at 0x10 (RAM 0x10..0x13 = 11,22,33,84), sext=0 -> rdata=0x84332211, done[0] for exactly one cycle, 5 cycles after grant.
- Byte read at 0x13 with sext=1 -> rdata=0xFFFFFF84; same with sext=0 -> 0x00000084.
- Ports 0 and 1 both hold req over three transfers -> grants in order 0,1,0 with a FIN cycle between each; done never goes to the ungranted port.
- Half write 0xBEEF to 0x3_0000 with uart_full_signal high for 3 cycles -> no write strobe during the stall; then bytes EF, BE at 0x30000/0x30001; done 3 cycles later than unthrottled.
- Drop req after byte 1 of a word write to 0x20 -> only 0x20 and 0x21 written, no done, IDLE next edge. Assert rst low mid-read -> outputs at reset values immediately.
- rdy low for 4 cycles in the middle of a word read -> result and done timing shifted by exactly 4 cycles.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request-side bundle for mem_arbiter: one flattened lane per port plus shared completion signals.
// The master drives requests and the arbiter (slave) answers with done/rdata/busy.
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [2*NUM_PORTS-1:0]      size;
  logic [NUM_PORTS-1:0]        sext;
  logic [ADDR_W*NUM_PORTS-1:0] addr;
  logic [32*NUM_PORTS-1:0]     wdata;
  logic [NUM_PORTS-1:0]        done;
  logic [31:0]                 rdata;
  logic                        busy;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  done, rdata, busy
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output done, rdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising 1/2/4-byte port transfers onto an 8-bit RAM bus; done one cycle after the last byte.
// Ports hold req until done; rdy low freezes everything; I/O writes stall while the UART is full.
module mem_arbiter #(
  parameter int                NUM_PORTS = 2,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_arbiter_if.slave      bus,
  input  logic [7:0]        data_from_ram,
  input  logic              uart_full_signal,
  output logic              signal_to_ram,
  output logic [ADDR_W-1:0] addr_to_ram,
  output logic [7:0]        data_to_ram
);
  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]           state;
  logic [PW-1:0]        ptr;
  logic                 lat_sext;
  logic [2:0]           nb;
  logic [2:0]           cnt;
  logic [ADDR_W-1:0]    lat_addr;
  logic [31:0]          lat_wdata;
  logic [NUM_PORTS-1:0] done_q;
  logic [31:0]          rdata_q;
  logic                 busy_q;

  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  // Rotating priority: scan upward from the port after the last grant.
  logic          gnt_vld;
  logic [PW-1:0] gnt;
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!gnt_vld && bus.req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  logic [1:0]        g_size;
  logic [2:0]        g_nb;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  always_comb begin
    g_size  = bus.size[2*gnt +: 2];
    g_addr  = bus.addr[ADDR_W*gnt +: ADDR_W];
    g_wdata = bus.wdata[32*gnt +: 32];
    g_nb    = (g_size == 2'b00) ? 3'd1 : (g_size == 2'b01) ? 3'd2 : 3'd4;
  end

  // Merge the incoming byte; on the final byte apply sign or zero extension.
  logic [31:0] rd_merge;
  logic [31:0] rd_final;
  always_comb begin
    rd_merge = rdata_q;
    rd_merge[{cnt[1:0], 3'b000} +: 8] = data_from_ram;
    rd_final = rd_merge;
    if (nb == 3'd1)
      rd_final = {{24{lat_sext & rd_merge[7]}}, rd_merge[7:0]};
    else if (nb == 3'd2)
      rd_final = {{16{lat_sext & rd_merge[15]}}, rd_merge[15:0]};
  end

  logic io_stall;
  logic g_stall;
  assign io_stall = (lat_addr >= IO_BASE) && uart_full_signal;
  assign g_stall  = (g_addr >= IO_BASE) && uart_full_signal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= PW'(NUM_PORTS - 1);
      lat_sext      <= 1'b0;
      nb            <= 3'd1;
      cnt           <= 3'd0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      signal_to_ram <= 1'b1;
      addr_to_ram   <= '0;
      data_to_ram   <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ptr       <= gnt;
            lat_sext  <= bus.sext[gnt];
            nb        <= g_nb;
            lat_addr  <= g_addr;
            lat_wdata <= g_wdata;
            busy_q    <= 1'b1;
            if (bus.we[gnt]) begin
              state <= WR;
              if (g_stall) begin
                cnt <= 3'd0;
              end else begin
                signal_to_ram <= 1'b0;
                addr_to_ram   <= g_addr;
                data_to_ram   <= g_wdata[7:0];
                cnt           <= 3'd1;
              end
            end else begin
              state       <= RD;
              rdata_q     <= '0;
              addr_to_ram <= g_addr;
              cnt         <= 3'd0;
            end
          end
        end
        // cnt is the byte whose data arrives at this edge.
        RD: begin
          if (|done_q) begin
            done_q <= '0;
            state  <= FIN;
          end else if (!bus.req[ptr]) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == nb - 3'd1) begin
            rdata_q <= rd_final;
            done_q  <= NUM_PORTS'(1) << ptr;
          end else begin
            rdata_q     <= rd_merge;
            cnt         <= cnt + 3'd1;
            addr_to_ram <= lat_addr + ADDR_W'(cnt + 3'd1);
          end
        end
        // cnt is the next byte to drive onto the bus.
        WR: begin
          if (|done_q) begin
            done_q <= '0;
            state  <= FIN;
          end else if (!bus.req[ptr]) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            signal_to_ram <= 1'b1;
          end else if (cnt == nb) begin
            signal_to_ram <= 1'b1;
            done_q        <= NUM_PORTS'(1) << ptr;
          end else if (io_stall) begin
            signal_to_ram <= 1'b1;
          end else begin
            signal_to_ram <= 1'b0;
            addr_to_ram   <= lat_addr + ADDR_W'(cnt);
            data_to_ram   <= lat_wdata[{cnt[1:0], 3'b000} +: 8];
            cnt           <= cnt + 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus random transfers against a byte-level memory model; checks data, write traffic and latency.
// The RAM model answers reads combinationally from the registered bus address and logs every write strobe.
module tb_mem_arbiter;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  data_from_ram;
  logic        uart_full_signal;
  logic        signal_to_ram;
  logic [31:0] addr_to_ram;
  logic [7:0]  data_to_ram;

  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) bus ();

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .IO_BASE(IO_BASE)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .bus              (bus),
    .data_from_ram    (data_from_ram),
    .uart_full_signal (uart_full_signal),
    .signal_to_ram    (signal_to_ram),
    .addr_to_ram      (addr_to_ram),
    .data_to_ram      (data_to_ram)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [7:0]  shadow [256];
  logic [39:0] wlog [$];
  logic        init_mem;
  int          checks = 0;
  int          errors = 0;
  int          last_grant;

  function automatic logic [7:0] pat(input int i);
    case (i)
      16: return 8'h11;
      17: return 8'h22;
      18: return 8'h33;
      19: return 8'h84;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // I/O space reads return an address-derived pattern.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (a < 32'd256) return shadow[a[7:0]];
    return a[7:0] ^ 8'h5A;
  endfunction

  assign data_from_ram = (addr_to_ram < 32'd256) ? mem[addr_to_ram[7:0]] : (addr_to_ram[7:0] ^ 8'h5A);

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (rst && rdy && !signal_to_ram) begin
      if (addr_to_ram < 32'd256) mem[addr_to_ram[7:0]] <= data_to_ram;
      wlog.push_back({addr_to_ram, data_to_ram});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int p, input bit w, input logic [1:0] sz, input bit sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int stall, input int frz_at, input int frz_len);
    int     n;
    int     exp_cyc;
    int     cyc;
    int     wbase;
    bit     seen;
    longint v;
    n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_cyc = n + 1 + frz_len + ((w && a >= IO_BASE) ? stall : 0);
    wbase   = wlog.size();
    bus.req              = '0;
    bus.req[p]           = 1'b1;
    bus.we[p]            = w;
    bus.size[2*p +: 2]   = sz;
    bus.sext[p]          = sx;
    bus.addr[32*p +: 32] = a;
    bus.wdata[32*p +: 32] = wd;
    uart_full_signal     = (stall > 0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == stall) uart_full_signal = 1'b0;
      if (cyc == frz_at) rdy = 1'b0;
      if (cyc == frz_at + frz_len) rdy = 1'b1;
      if (w && a >= IO_BASE && stall > 0 && cyc == stall)
        chk("stall_no_strobe", signal_to_ram, 1'b1);
      if (bus.done != 0) seen = 1;
    end
    chk("done_port", bus.done, 64'(1) << p);
    chk("latency", cyc, exp_cyc);
    if (!w) begin
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ram_byte(a + 32'(k))) << (8 * k);
      if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      chk("rdata", bus.rdata, v[31:0]);
    end
    bus.req[p] = 1'b0;
    tick();
    chk("fin_done_low", bus.done, 0);
    chk("fin_busy", bus.busy, 1'b1);
    tick();
    chk("idle_busy", bus.busy, 1'b0);
    if (w) begin
      chk("wr_count", wlog.size() - wbase, n);
      for (int k = 0; k < n; k++) begin
        chk("wr_byte", (wbase + k < wlog.size()) ? wlog[wbase + k] : 40'hFF_FFFF_FFFF,
            {a + 32'(k), wd[8*k +: 8]});
        if (a + 32'(k) < 32'd256) shadow[8'(a + 32'(k))] = wd[8*k +: 8];
      end
    end
    last_grant = p;
  endtask

  initial begin
    int          wb;
    int          mism;
    int          p;
    bit          w;
    bit          sx;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    rst              = 1'b1;
    rdy              = 1'b1;
    init_mem         = 1'b1;
    uart_full_signal = 1'b0;
    bus.req   = '0;
    bus.we    = '0;
    bus.size  = '0;
    bus.sext  = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_strobe", signal_to_ram, 1'b1);
    chk("rst_addr", addr_to_ram, 0);
    chk("rst_wdata", data_to_ram, 0);
    tick();
    init_mem = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    last_grant = 1;

    xfer(0, 0, 2'b10, 0, 32'h10, 0, 0, -1, 0);
    xfer(0, 0, 2'b00, 1, 32'h13, 0, 0, -1, 0);
    xfer(1, 0, 2'b00, 0, 32'h13, 0, 0, -1, 0);
    xfer(0, 1, 2'b01, 0, IO_BASE, 32'h0000_BEEF, 0, -1, 0);
    xfer(0, 1, 2'b01, 0, IO_BASE, 32'h0000_BEEF, 3, -1, 0);
    xfer(1, 0, 2'b10, 0, 32'h10, 0, 0, 2, 4);
    xfer(0, 0, 2'b10, 0, 32'hFFFF_FFFE, 0, 0, -1, 0);
    xfer(1, 0, 2'b01, 1, 32'h12, 0, 0, -1, 0);

    repeat (40) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? IO_BASE + $urandom_range(0, 63) : 32'h40 + $urandom_range(0, 8'hB0);
      xfer(p, w, sz, sx, a, $urandom, int'($urandom_range(0, 2)), -1, 0);
    end

    // Word write abandoned once byte 1 is on the bus.
    wb = wlog.size();
    bus.req = 2'b01;
    bus.we[0] = 1'b1;
    bus.size[1:0] = 2'b10;
    bus.addr[31:0] = 32'h20;
    bus.wdata[31:0] = 32'hA1B2_C3D4;
    tick();
    tick();
    chk("abort_byte1_bus", {signal_to_ram, addr_to_ram}, {1'b0, 32'h21});
    bus.req[0] = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_strobe", signal_to_ram, 1'b1);
    tick();
    tick();
    chk("abort_no_done", bus.done, 0);
    chk("abort_wr_count", wlog.size() - wb, 2);
    chk("abort_wr0", (wb < wlog.size()) ? wlog[wb] : 40'hFF_FFFF_FFFF, {32'h20, 8'hD4});
    chk("abort_wr1", (wb + 1 < wlog.size()) ? wlog[wb + 1] : 40'hFF_FFFF_FFFF, {32'h21, 8'hC3});
    shadow[8'h20] = 8'hD4;
    shadow[8'h21] = 8'hC3;
    last_grant = 0;

    // Asynchronous reset in the middle of a word read.
    bus.req = 2'b10;
    bus.we[1] = 1'b0;
    bus.size[3:2] = 2'b10;
    bus.addr[63:32] = 32'h10;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    chk("mid_rst_strobe", signal_to_ram, 1'b1);
    chk("mid_rst_addr", addr_to_ram, 0);
    bus.req = 2'b00;
    @(negedge clk) rst = 1'b1;
    tick();
    last_grant = 1;

    // Both ports requesting continuously: grants alternate, starting at port 0.
    bus.we = 2'b00;
    bus.size = 4'b0000;
    bus.sext = 2'b00;
    bus.addr = {32'h11, 32'h10};
    bus.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      int ep;
      int cyc;
      ep  = (last_grant + 1) % 2;
      cyc = 0;
      while (bus.done == 0 && cyc < 30) begin
        tick();
        cyc++;
      end
      chk("arb_done", bus.done, 64'(1) << ep);
      chk("arb_rdata", bus.rdata, {24'h0, ram_byte((ep == 0) ? 32'h10 : 32'h11)});
      last_grant = ep;
      tick();
      chk("arb_fin_gap", {bus.done, bus.busy}, 3'b001);
    end
    bus.req = 2'b00;
    repeat (4) tick();

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) mism++;
    chk("mem_image", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
